// File: rtl/qdma_qsts_marker_trk.sv
// Queue-status marker tracker: each channel waits for a status beat that
// matches its requested opcode (and, optionally, its qid). It then reports
// completion with the captured payload, or a timeout if no beat arrives.
module qdma_qsts_marker_trk #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned TOUT_W = 16,
   parameter int unsigned QID_W  = 13
) (
   input  logic                     axi_aclk,
   input  logic                     axi_aresetn,
   input  logic [7:0]               qsts_out_op,
   input  logic [63:0]              qsts_out_data,
   input  logic [2:0]               qsts_out_port_id,
   input  logic [QID_W-1:0]         qsts_out_qid,
   input  logic                     qsts_out_vld,
   output logic                     qsts_out_rdy,
   input  logic [NUM_CH-1:0]        marker_req,
   input  logic [8*NUM_CH-1:0]      marker_op,
   input  logic [QID_W*NUM_CH-1:0]  marker_qid,
   input  logic [NUM_CH-1:0]        marker_qid_en,
   input  logic [TOUT_W-1:0]        timeout_cycles,
   output logic [NUM_CH-1:0]        marker_rsp,
   output logic [NUM_CH-1:0]        marker_err,
   output logic [64*NUM_CH-1:0]     marker_data,
   output logic [15:0]              unmatched_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_TOUT = 2'd3
   } state_t;

   state_t              r_state     [NUM_CH];
   state_t              w_state_nxt [NUM_CH];
   logic [TOUT_W-1:0]   r_cnt       [NUM_CH];
   logic [TOUT_W-1:0]   w_cnt_nxt   [NUM_CH];
   logic [63:0]         r_data      [NUM_CH];
   logic [NUM_CH-1:0]   w_hit;
   logic [NUM_CH-1:0]   w_armed;
   logic [NUM_CH-1:0]   w_load;
   logic                w_unmatched;
   logic [15:0]         r_unmatched;
   logic                w_unused;

   // The port id plays no part in matching.
   assign w_unused     = ^qsts_out_port_id;
   assign qsts_out_rdy = 1'b1;

   // Per-channel match of the current status beat.
   always_comb begin
      w_hit = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         w_hit[c] = qsts_out_vld
                 && (qsts_out_op == marker_op[c*8 +: 8])
                 && (!marker_qid_en[c] || (qsts_out_qid == marker_qid[c*QID_W +: QID_W]));
      end
   end

   // Next-state, counter and capture-enable for every channel.
   always_comb begin
      w_load  = '0;
      w_armed = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         w_state_nxt[c] = r_state[c];
         w_cnt_nxt[c]   = r_cnt[c];
         case (r_state[c])
            S_IDLE: begin
               if (marker_req[c]) begin
                  w_armed[c] = 1'b1;
                  if (w_hit[c]) begin
                     w_state_nxt[c] = S_DONE;
                     w_load[c]      = 1'b1;
                  end else begin
                     w_state_nxt[c] = S_WAIT;
                     w_cnt_nxt[c]   = '0;
                  end
               end
            end
            S_WAIT: begin
               w_armed[c] = 1'b1;
               if (!marker_req[c]) begin
                  w_state_nxt[c] = S_IDLE;
               end else if (w_hit[c]) begin
                  w_state_nxt[c] = S_DONE;
                  w_load[c]      = 1'b1;
               // >= keeps the counter bounded if the timeout shrinks mid-wait
               end else if ((timeout_cycles != '0)
                         && (r_cnt[c] >= timeout_cycles - TOUT_W'(1))) begin
                  w_state_nxt[c] = S_TOUT;
               end else if (r_cnt[c] != '1) begin
                  w_cnt_nxt[c] = r_cnt[c] + TOUT_W'(1);
               end
            end
            S_DONE, S_TOUT: begin
               if (!marker_req[c]) begin
                  w_state_nxt[c] = S_IDLE;
               end
            end
            default: w_state_nxt[c] = S_IDLE;
         endcase
      end
   end

   // Channel state, wait counters and captured payloads.
   always_ff @(posedge axi_aclk) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (!axi_aresetn) begin
            r_state[c] <= S_IDLE;
            r_cnt[c]   <= '0;
            r_data[c]  <= '0;
         end else begin
            r_state[c] <= w_state_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
            if (w_load[c]) begin
               r_data[c] <= qsts_out_data;
            end
         end
      end
   end

   assign w_unmatched = qsts_out_vld && ((w_hit & w_armed) == '0);

   // Saturating count of beats that no armed channel consumed.
   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         r_unmatched <= '0;
      end else if (w_unmatched && (r_unmatched != '1)) begin
         r_unmatched <= r_unmatched + 16'd1;
      end
   end

   // Outputs decode directly from the channel state registers.
   always_comb begin
      marker_rsp  = '0;
      marker_err  = '0;
      marker_data = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         marker_rsp[c]           = (r_state[c] == S_DONE);
         marker_err[c]           = (r_state[c] == S_TOUT);
         marker_data[c*64 +: 64] = r_data[c];
      end
   end

   assign unmatched_cnt = r_unmatched;

endmodule

// File: tb/tb_qdma_qsts_marker_trk.sv
// Bench for qdma_qsts_marker_trk: flag-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_qdma_qsts_marker_trk;

   localparam int NCH = 4;
   localparam int TW  = 16;
   localparam int QW  = 13;

   logic              clk = 1'b0;
   logic              rstn;
   logic [7:0]        op;
   logic [63:0]       data;
   logic [2:0]        port_id;
   logic [QW-1:0]     qid;
   logic              vld;
   logic              rdy;
   logic [NCH-1:0]    req;
   logic [8*NCH-1:0]  mop;
   logic [QW*NCH-1:0] mqid;
   logic [NCH-1:0]    qen;
   logic [TW-1:0]     tout;
   logic [NCH-1:0]    rsp;
   logic [NCH-1:0]    err;
   logic [64*NCH-1:0] mdata;
   logic [15:0]       unm;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   // model state
   bit          m_wait [NCH];
   bit          m_rsp  [NCH];
   bit          m_err  [NCH];
   logic [63:0] m_data [NCH];
   int          m_age  [NCH];
   int          m_unm;

   qdma_qsts_marker_trk #(.NUM_CH(NCH), .TOUT_W(TW), .QID_W(QW)) dut (
      .axi_aclk(clk), .axi_aresetn(rstn),
      .qsts_out_op(op), .qsts_out_data(data), .qsts_out_port_id(port_id),
      .qsts_out_qid(qid), .qsts_out_vld(vld), .qsts_out_rdy(rdy),
      .marker_req(req), .marker_op(mop), .marker_qid(mqid),
      .marker_qid_en(qen), .timeout_cycles(tout),
      .marker_rsp(rsp), .marker_err(err), .marker_data(mdata),
      .unmatched_cnt(unm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end
   endtask

   // Channel behaviour: a request is either pending (first cycle or waiting),
   // completed, or timed out; age counts cycles since the request was seen.
   task automatic model_step();
      bit any, hit, armed;
      if (!rstn) begin
         for (int c = 0; c < NCH; c++) begin
            m_wait[c] = 0; m_rsp[c] = 0; m_err[c] = 0; m_data[c] = '0; m_age[c] = 0;
         end
         m_unm = 0;
      end else begin
         any = 0;
         for (int c = 0; c < NCH; c++) begin
            hit = vld && (op == mop[c*8 +: 8]) && (!qen[c] || qid == mqid[c*QW +: QW]);
            armed = m_wait[c] || (!m_rsp[c] && !m_err[c] && req[c]);
            if (hit && armed) any = 1;
            if (m_wait[c]) begin
               if (!req[c]) m_wait[c] = 0;
               else if (hit) begin m_wait[c] = 0; m_rsp[c] = 1; m_data[c] = data; end
               else if (tout != 0 && m_age[c] >= int'(tout)) begin m_wait[c] = 0; m_err[c] = 1; end
               else m_age[c]++;
            end else if (m_rsp[c] || m_err[c]) begin
               if (!req[c]) begin m_rsp[c] = 0; m_err[c] = 0; end
            end else if (req[c]) begin
               if (hit) begin m_rsp[c] = 1; m_data[c] = data; end
               else begin m_wait[c] = 1; m_age[c] = 1; end
            end
         end
         if (vld && !any && m_unm < 65535) m_unm++;
      end
   endtask

   task automatic compare();
      logic [NCH-1:0]    er, ee;
      logic [64*NCH-1:0] ed;
      for (int c = 0; c < NCH; c++) begin
         er[c] = m_rsp[c];
         ee[c] = m_err[c];
         ed[c*64 +: 64] = m_data[c];
      end
      chk("cyc_rsp", rsp, er);
      chk("cyc_err", err, ee);
      chk("cyc_data", mdata, ed);
      chk("cyc_unm", unm, m_unm);
      chk("cyc_rdy", rdy, 1);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) compare();
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic beat(input logic [7:0] o, input logic [QW-1:0] q, input logic [63:0] d);
      op = o; qid = q; data = d; vld = 1;
      @(negedge clk);
      vld = 0;
   endtask

   initial begin
      rstn = 0; op = 0; data = 0; port_id = 3'd5; qid = 0; vld = 0;
      req = 0; mop = 0; mqid = 0; qen = 0; tout = 0;
      step(1);
      cmp_en = 1;
      step(2);
      chk("rst_rsp", rsp, 0);
      chk("rst_err", err, 0);
      chk("rst_data", mdata, 0);
      chk("rst_unm", unm, 0);
      chk("rst_rdy", rdy, 1);
      rstn = 1;
      step(1);

      // basic completion on ch0 after three idle cycles
      mop[0*8 +: 8] = 8'd0; qen[0] = 0; req[0] = 1;
      step(3);
      beat(8'd0, 13'd7, 64'hA5);
      chk("s1_rsp0", rsp[0], 1);
      chk("s1_data0", mdata[0 +: 64], 64'hA5);
      chk("s1_unm", unm, 0);
      req[0] = 0;
      step(1);
      chk("s1_rsp0_low", rsp[0], 0);
      chk("s1_data0_hold", mdata[0 +: 64], 64'hA5);

      // qid filtering on ch1
      mop[1*8 +: 8] = 8'd1; qen[1] = 1; mqid[1*QW +: QW] = 13'd5; req[1] = 1;
      step(1);
      beat(8'd1, 13'd4, 64'h11);
      chk("s2_unm1", unm, 1);
      chk("s2_rsp1_wait", rsp[1], 0);
      beat(8'd1, 13'd5, 64'h22);
      chk("s2_rsp1", rsp[1], 1);
      chk("s2_data1", mdata[64 +: 64], 64'h22);
      req[1] = 0;
      step(1);

      // timeout on ch2 with T=4, then disabled timeout
      tout = 16'd4; mop[2*8 +: 8] = 8'd2; req[2] = 1;
      step(4);
      chk("s3_err2_early", err[2], 0);
      step(1);
      chk("s3_err2", err[2], 1);
      chk("s3_rsp2", rsp[2], 0);
      req[2] = 0;
      step(1);
      chk("s3_err2_low", err[2], 0);
      tout = 16'd0; req[2] = 1;
      step(1000);
      chk("s3_no_tout", err[2], 0);
      req[2] = 0;
      step(1);

      // hit on the exact timeout cycle wins
      tout = 16'd4; req[2] = 1;
      step(4);
      beat(8'd2, 13'd0, 64'h33);
      chk("s4_rsp2", rsp[2], 1);
      chk("s4_err2", err[2], 0);
      chk("s4_data2", mdata[128 +: 64], 64'h33);
      step(3);
      chk("s4_err2_hold", err[2], 0);
      req[2] = 0;
      step(1);

      // broadcast to ch0 and ch3; a later beat while done is unmatched
      mop[0*8 +: 8] = 8'd3; mop[3*8 +: 8] = 8'd3; qen[0] = 0; qen[3] = 0;
      req[0] = 1; req[3] = 1;
      step(1);
      beat(8'd3, 13'd9, 64'h44);
      chk("s5_rsp", rsp, 4'b1001);
      chk("s5_unm", unm, 1);
      chk("s5_data3", mdata[192 +: 64], 64'h44);
      beat(8'd3, 13'd9, 64'h45);
      chk("s5_unm2", unm, 2);
      chk("s5_data0_hold", mdata[0 +: 64], 64'h44);
      req[0] = 0; req[3] = 0;
      step(1);

      // saturation of the unmatched counter
      tout = 16'd0; op = 8'h55; vld = 1;
      step(70000);
      vld = 0;
      step(1);
      chk("s6_sat", unm, 16'hFFFF);

      // reset with ch1 done and ch2 waiting, then re-arm
      req[1] = 1; req[2] = 1;
      beat(8'd1, 13'd5, 64'h77);
      chk("s6_rsp1", rsp[1], 1);
      step(2);
      rstn = 0;
      step(1);
      chk("s6_rst_rsp", rsp, 0);
      chk("s6_rst_err", err, 0);
      chk("s6_rst_data", mdata, 0);
      chk("s6_rst_unm", unm, 0);
      rstn = 1;
      beat(8'd1, 13'd5, 64'h66);
      chk("s6_rearm_rsp1", rsp[1], 1);
      chk("s6_rearm_data1", mdata[64 +: 64], 64'h66);
      chk("s6_rearm_unm", unm, 0);
      req = 0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
